mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have ports clk input 1 (clock) and reset input 1 (reset, synchronous, active-high), listed first.
REQ-002 The block SHALL have port start input 4 carrying the E-stage op code: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7-15 none.
REQ-003 The block SHALL have ports rs input 32 (operand A / move source) and rt input 32 (operand B).
REQ-004 The block SHALL have port req input 1, asserted when an exception or interrupt flushes the pipeline this cycle.
REQ-005 The block SHALL have port hl_sel input 1 selecting the read value: 0 LO, 1 HI.
REQ-006 The block SHALL have port rdata output 32 carrying the selected committed HI or LO.
REQ-007 The block SHALL have ports busy output 1 (operation in flight) and stall output 1 (busy OR an accepted multiply/divide start this cycle, combinational).
REQ-008 The block SHALL have ports hi output 32 and lo output 32 carrying the committed registers.

Function
REQ-009 A start SHALL be accepted only when start is in 1..6, req=0 and busy=0; any other start SHALL be ignored.
REQ-010 An accepted MTHI/MTLO SHALL write rs to HI/LO at the next clock edge with no busy period.
REQ-011 An accepted MULT/MULTU SHALL latch the 64-bit product of rs and rt (signed or unsigned) and load the down-counter with 5.
REQ-012 An accepted DIV/DIVU SHALL latch quotient and remainder and load the down-counter with 10.
REQ-013 busy SHALL be 1 from the edge after acceptance while the counter is non-zero; the counter SHALL decrement by 1 per cycle.
REQ-014 HI/LO SHALL update on the edge where the counter goes 1->0. Multiply latency SHALL be 5 busy cycles; divide latency SHALL be 10 busy cycles.
REQ-015 Multiply results SHALL be HI = product[63:32] and LO = product[31:0].
REQ-016 Divide results SHALL be LO = quotient and HI = remainder. Signed division SHALL truncate toward zero, and the remainder SHALL take the dividend's sign.
REQ-017 A divide with rt=0 SHALL run the full 10 cycles and leave HI/LO unchanged.
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-019 req asserted while busy SHALL NOT abort the in-flight operation, because it belongs to an older committed instruction.
REQ-020 rdata SHALL reflect committed HI/LO only and SHALL NOT show pending results. The pipeline uses stall to block MFHI/MFLO and further MD ops while busy.
REQ-021 A start arriving while busy=1 SHALL be ignored, with no queuing. Upstream holds it via stall.
REQ-022 On the final busy cycle busy SHALL still read 1, and it SHALL read 0 on the following cycle, when new HI/LO are visible.

Reset
REQ-023 When reset=1 at a clock edge, the block SHALL set HI=0, LO=0, counter=0, busy=0 and clear the pending-result registers.
REQ-024 reset SHALL take priority over start, req and counter activity, and SHALL cancel any in-flight operation with no HI/LO update.
REQ-025 After reset, rdata SHALL be 0 and stall SHALL be 0 until a multiply/divide start is presented.

Structure
REQ-026 Op-code constants (MD_NONE..MD_MTLO) and the latencies MUL_LAT=5 and DIV_LAT=10 SHALL live in the shared CPU constants package.
REQ-027 The block SHALL be one module with no sub-module. Arithmetic SHALL use behavioural * / % on 64/32-bit signed and unsigned casts.
REQ-028 Pending HI/LO SHALL be held in dedicated 32-bit registers, separate from committed HI/LO.

Verification
REQ-029 Scenario: MULT rs=0xFFFFFFFE (-2), rt=3 -> busy for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-030 Scenario: MULTU rs=0xFFFFFFFF, rt=2 -> after 5 cycles HI=0x00000001 and LO=0xFFFFFFFE.
REQ-031 Scenario: DIV rs=-7, rt=2 -> busy for 10 cycles, then LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1). A DIVU started during busy is ignored.
REQ-032 Scenario: DIV rt=0 with HI=0x11, LO=0x22 beforehand -> after 10 cycles HI=0x11 and LO=0x22.
REQ-033 Scenario: MULT start with req=1 -> busy stays 0 and HI/LO are unchanged. req=1 at cycle 3 of an in-flight MULT -> the result still commits at cycle 5.
REQ-034 Scenario: reset asserted at cycle 4 of a DIV -> busy=0, HI=0, LO=0, and no later update; then MTLO rs=0x1234 -> LO=0x1234 the next cycle, hl_sel=0 -> rdata=0x1234.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared CPU constants for the HI/LO multiply/divide unit: E-stage op codes
// and the fixed busy latencies of the iterative-looking multiply and divide.
package mul_div_unit_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;

    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned DIV_LAT = 10;

    // True for op codes that occupy the unit for a busy period.
    function automatic logic is_md_op(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    // True for every op code the unit acts on (arithmetic and moves).
    function automatic logic is_valid_op(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_MTLO);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit. Results are computed behaviourally at start,
// parked in pending registers, and committed to HI/LO when the down-counter
// expires, which models the fixed multi-cycle latency seen by the pipeline.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  start,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        req,
    input  logic        hl_sel,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [3:0]         cnt;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               pend_we;

    logic               accept;
    logic               accept_md;

    logic signed [63:0] op_a_s;
    logic signed [63:0] op_b_s;
    logic signed [63:0] div_b_s;
    logic [31:0]        div_b_u;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        quot_s;
    logic [31:0]        rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;

    assign busy      = (cnt != '0);
    assign accept    = is_valid_op(start) && !req && !busy;
    assign accept_md = accept && is_md_op(start);
    assign stall     = busy | accept_md;
    assign rdata     = hl_sel ? hi : lo;

    // Operand preparation and behavioural multiply/divide results.
    // Signed divide runs on 64-bit sign-extended operands so that
    // 0x80000000 / -1 wraps to 0x80000000 with remainder 0 instead of
    // overflowing; a zero divisor is replaced by 1 and its result discarded.
    always_comb begin
        op_a_s  = {{32{rs[31]}}, rs};
        op_b_s  = {{32{rt[31]}}, rt};
        div_b_s = (rt == '0) ? 64'sd1 : op_b_s;
        div_b_u = (rt == '0) ? 32'd1 : rt;
        prod_s  = op_a_s * op_b_s;
        prod_u  = {32'd0, rs} * {32'd0, rt};
        quot_s  = 32'(op_a_s / div_b_s);
        rem_s   = 32'(op_a_s % div_b_s);
        quot_u  = rs / div_b_u;
        rem_u   = rs % div_b_u;
    end

    // Latency counter and pending-result capture on an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_we <= 1'b0;
        end else if (busy) begin
            cnt <= cnt - 4'd1;
        end else if (accept) begin
            case (start)
                MD_MULT: begin
                    pend_hi <= prod_s[63:32];
                    pend_lo <= prod_s[31:0];
                    pend_we <= 1'b1;
                    cnt     <= 4'(MUL_LAT);
                end
                MD_MULTU: begin
                    pend_hi <= prod_u[63:32];
                    pend_lo <= prod_u[31:0];
                    pend_we <= 1'b1;
                    cnt     <= 4'(MUL_LAT);
                end
                MD_DIV: begin
                    pend_hi <= rem_s;
                    pend_lo <= quot_s;
                    pend_we <= (rt != '0);
                    cnt     <= 4'(DIV_LAT);
                end
                MD_DIVU: begin
                    pend_hi <= rem_u;
                    pend_lo <= quot_u;
                    pend_we <= (rt != '0);
                    cnt     <= 4'(DIV_LAT);
                end
                default: ;
            endcase
        end
    end

    // Committed HI/LO: written by moves immediately, by arithmetic on expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (busy) begin
            if (cnt == 4'd1 && pend_we) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end else if (accept) begin
            if (start == MD_MTHI) hi <= rs;
            if (start == MD_MTLO) lo <= rs;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed scenarios plus randomized ops,
// checked against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  start;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        req;
    logic        hl_sel;
    logic [31:0] rdata;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned lat;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int          busy_left = 0;
    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    mul_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .rs    (rs),
        .rt    (rt),
        .req   (req),
        .hl_sel(hl_sel),
        .rdata (rdata),
        .busy  (busy),
        .stall (stall),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected HI/LO whenever the DUT finishes an operation.
    initial begin
        logic        busy_prev;
        int unsigned run;
        exp_t        e;
        busy_prev = 1'b0;
        run = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_prev = 1'b0;
                run = 0;
            end else begin
                if (busy) begin
                    run++;
                end else if (busy_prev || (q.size() != 0 && q[0].lat == 0)) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: got completion expected none at %0t", $time);
                    end else begin
                        e = q.pop_front();
                        chk("hi", hi, e.hi);
                        chk("lo", lo, e.lo);
                        chk("rdata", rdata, hl_sel ? e.hi : e.lo);
                        chk("latency", 32'(run), 32'(e.lat));
                    end
                    run = 0;
                end
                busy_prev = busy;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (busy_left > 0) busy_left--;
    endtask

    // Reference arithmetic from the sign/magnitude rules.
    task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl);
        longint sa, sb, ma, mb, qm, rm;
        logic [63:0] p;
        rh = ref_hi;
        rl = ref_lo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MD_MULT: begin
                p  = 64'(sa * sb);
                rh = p[63:32];
                rl = p[31:0];
            end
            MD_MULTU: begin
                p  = {32'd0, a} * {32'd0, b};
                rh = p[63:32];
                rl = p[31:0];
            end
            MD_DIV: if (b != 0) begin
                ma = (sa < 0) ? -sa : sa;
                mb = (sb < 0) ? -sb : sb;
                qm = ma / mb;
                rm = ma % mb;
                rl = 32'(((sa < 0) != (sb < 0)) ? -qm : qm);
                rh = 32'((sa < 0) ? -rm : rm);
            end
            MD_DIVU: if (b != 0) begin
                rl = a / b;
                rh = a % b;
            end
            MD_MTHI: rh = a;
            MD_MTLO: rl = a;
            default: ;
        endcase
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic r);
        logic acc, md;
        exp_t e;
        logic [31:0] rh, rl;
        start  = op;
        rs     = a;
        rt     = b;
        req    = r;
        hl_sel = 1'($urandom);
        #1;
        acc = (op >= 4'd1) && (op <= 4'd6) && !r && (busy_left == 0);
        md  = acc && (op <= 4'd4);
        chk("busy", {31'd0, busy}, {31'd0, busy_left > 0});
        chk("stall", {31'd0, stall}, {31'd0, (busy_left > 0) || md});
        ref_op(op, a, b, rh, rl);
        if (md) begin
            e.hi  = rh;
            e.lo  = rl;
            e.lat = (op <= 4'd2) ? 5 : 10;
            q.push_back(e);
            ref_hi = rh;
            ref_lo = rl;
        end
        tick();
        start = 4'd0;
        req   = 1'b0;
        if (md) busy_left = (op <= 4'd2) ? 5 : 10;
        if (acc && !md) begin
            ref_hi = rh;
            ref_lo = rl;
            e.hi  = rh;
            e.lo  = rl;
            e.lat = 0;
            q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: got %0d pending results expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 4'd0;
        req   = 1'b0;
        tick();
        reset = 1'b0;
        q.delete();
        busy_left = 0;
        ref_hi = '0;
        ref_lo = '0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] op;
        reset = 1'b1; start = 4'd0; rs = '0; rt = '0; req = 1'b0; hl_sel = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);

        // MULT -2 * 3
        do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_idle();
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // MULTU 0xFFFFFFFF * 2
        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        wait_idle();
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // DIV -7 / 2 with an ignored DIVU during busy
        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(MD_DIVU, 32'd100, 32'd7, 1'b0);
        wait_idle();
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // Divide by zero keeps HI/LO
        do_op(MD_MTHI, 32'h11, 32'd0, 1'b0);
        do_op(MD_MTLO, 32'h22, 32'd0, 1'b0);
        do_op(MD_DIV, 32'd1234, 32'd0, 1'b0);
        wait_idle();
        chk("dz_hi", hi, 32'h11);
        chk("dz_lo", lo, 32'h22);

        // Signed overflow case
        do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'h0);

        // Flushed start ignored; req mid-flight does not abort
        do_op(MD_MULT, 32'd9, 32'd9, 1'b1);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        do_op(MD_MULT, 32'd6, 32'd7, 1'b0);
        tick();
        do_op(MD_NONE, 32'd0, 32'd0, 1'b1);
        wait_idle();
        chk("req_mid_lo", lo, 32'd42);

        // Reset during a DIV cancels it
        do_op(MD_DIVU, 32'd1000, 32'd3, 1'b0);
        tick();
        tick();
        do_reset();
        chk("rdiv_busy", {31'd0, busy}, 32'd0);
        chk("rdiv_hi", hi, 32'h0);
        chk("rdiv_lo", lo, 32'h0);
        repeat (12) tick();
        chk("rdiv_late_hi", hi, 32'h0);
        chk("rdiv_late_lo", lo, 32'h0);
        do_op(MD_MTLO, 32'h1234, 32'd0, 1'b0);
        hl_sel = 1'b0;
        #1;
        chk("mtlo_rdata", rdata, 32'h1234);
        wait_idle();

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(1, 6));
            else                           op = 4'($urandom_range(0, 15));
            do_op(op, pick(), pick(), ($urandom_range(0, 7) == 0));
        end
        wait_idle();
        chk("drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
